// File: rtl/rd_fwft_stage.sv
// Read-side FWFT output stage of the async FIFO: converts rempty/rinc plus a
// one-cycle synchronous memory read into a registered valid/ready stream.
module rd_fwft_stage #(
  parameter int DSIZE = 8
) (
  input  logic             rclk,
  input  logic             rrst_n,
  input  logic             rempty,
  output logic             rinc,
  input  logic [DSIZE-1:0] mem_rdata,
  output logic [DSIZE-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [1:0]       out_count
);

  logic [DSIZE-1:0] e0, e1, e0_next, e1_next;
  logic [1:0]       cnt, cnt_next;
  logic             inflight;
  logic             pop;
  logic [2:0]       occ;

  assign out_valid = (cnt != 2'd0);
  assign out_data  = e0;
  assign out_count = cnt;
  assign pop       = out_valid & out_ready;

  // Occupancy after this cycle; pop implies cnt>0, so the subtraction cannot wrap.
  assign occ  = {1'b0, cnt} + {2'b00, inflight} - {2'b00, pop};
  assign rinc = rrst_n & ~rempty & (occ < 3'd2);

  always_comb begin
    // NOTE: every comb output gets a default first so no path infers a latch.
    e0_next  = e0;
    e1_next  = e1;
    cnt_next = occ[1:0];
    case ({inflight, pop})
      2'b01: e0_next = e1;
      2'b10: begin
        if (cnt == 2'd0) e0_next = mem_rdata;
        else             e1_next = mem_rdata;
      end
      2'b11: begin
        if (cnt == 2'd2) begin
          e0_next = e1;
          e1_next = mem_rdata;
        end else begin
          e0_next = mem_rdata;
        end
      end
      default: ;
    endcase
  end

  // NOTE: state uses non-blocking assignments; the data entries are reset too
  // because out_data is driven straight from e0 and must read 0 in reset.
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      cnt      <= 2'd0;
      inflight <= 1'b0;
      e0       <= '0;
      e1       <= '0;
    end else begin
      cnt      <= cnt_next;
      inflight <= rinc;
      e0       <= e0_next;
      e1       <= e1_next;
    end
  end

  a_no_overflow: assert property (@(posedge rclk) disable iff (!rrst_n) occ <= 3'd2);
  a_no_rinc_empty: assert property (@(posedge rclk) disable iff (!rrst_n) !(rinc && rempty));

endmodule

// File: tb/tb_rd_fwft_stage.sv
// Directed and randomised bench for rd_fwft_stage with a small FIFO read-side
// model (memory, read pointer, empty flag) and an in-order scoreboard.
module tb_rd_fwft_stage;

  logic       rclk = 1'b0;
  logic       rrst_n = 1'b0;
  logic       rempty;
  logic       rinc;
  logic [7:0] mem_rdata = 8'h00;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [1:0] out_count;

  logic [7:0] mem [0:2047];
  int         raddr = 0;
  int         wr_limit = 0;
  logic       gate_empty = 1'b0;

  int n_checks = 0;
  int n_errors = 0;

  rd_fwft_stage #(.DSIZE(8)) dut (
    .rclk      (rclk),
    .rrst_n    (rrst_n),
    .rempty    (rempty),
    .rinc      (rinc),
    .mem_rdata (mem_rdata),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_count (out_count)
  );

  always #5 rclk = ~rclk;

  // Read-side model: synchronous memory read and read pointer.
  assign rempty = gate_empty | (raddr == wr_limit);

  always @(posedge rclk) mem_rdata <= mem[raddr];

  always @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n)   raddr <= 0;
    else if (rinc) raddr <= raddr + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic smp();
    @(negedge rclk);
    #1;
  endtask

  task automatic drive_edge();
    @(posedge rclk);
    #1;
  endtask

  // Scoreboard and stream-rule monitor.
  int         sb_idx = 0;
  logic       hold_prev = 1'b0;
  logic [7:0] hold_data = 8'h00;

  always @(negedge rclk) begin
    if (!rrst_n) begin
      sb_idx    = 0;
      hold_prev = 1'b0;
    end else begin
      check("rinc_while_empty", {31'b0, rinc & rempty}, 32'd0);
      check("count_max", {31'b0, out_count <= 2'd2}, 32'd1);
      if (hold_prev) begin
        check("hold_valid", {31'b0, out_valid}, 32'd1);
        check("hold_data", {24'b0, out_data}, {24'b0, hold_data});
      end
      if (out_valid && out_ready) begin
        check("order", {24'b0, out_data}, {24'b0, mem[sb_idx]});
        sb_idx++;
      end
      hold_prev = out_valid & ~out_ready;
      hold_data = out_data;
    end
  end

  int n_rinc;

  initial begin
    // Reset with a non-empty FIFO.
    mem[0]   = 8'h3C;
    wr_limit = 1;
    repeat (3) @(posedge rclk);
    smp();
    check("rst_rinc", {31'b0, rinc}, 32'd0);
    check("rst_valid", {31'b0, out_valid}, 32'd0);
    check("rst_count", {30'b0, out_count}, 32'd0);
    check("rst_data", {24'b0, out_data}, 32'd0);
    drive_edge();
    rrst_n    = 1'b1;
    out_ready = 1'b1;
    smp();
    check("rel_rinc", {31'b0, rinc}, 32'd1);
    smp();
    check("rel_valid_n1", {31'b0, out_valid}, 32'd0);
    smp();
    check("rel_valid_n2", {31'b0, out_valid}, 32'd1);
    check("rel_data", {24'b0, out_data}, 32'h3C);
    smp();
    check("rel_drained", {31'b0, out_valid}, 32'd0);

    // Single word latency.
    drive_edge();
    out_ready = 1'b0;
    mem[1]    = 8'hA5;
    wr_limit  = 2;
    smp();
    check("single_rinc", {31'b0, rinc}, 32'd1);
    smp();
    check("single_valid_n1", {31'b0, out_valid}, 32'd0);
    check("single_rinc_n1", {31'b0, rinc}, 32'd0);
    smp();
    check("single_valid_n2", {31'b0, out_valid}, 32'd1);
    check("single_data", {24'b0, out_data}, 32'hA5);
    check("single_count", {30'b0, out_count}, 32'd1);
    drive_edge();
    out_ready = 1'b1;
    smp();
    check("single_pop_valid", {31'b0, out_valid}, 32'd1);
    drive_edge();
    out_ready = 1'b0;
    smp();
    check("single_after_pop", {31'b0, out_valid}, 32'd0);

    // Streaming 16 words with no bubbles.
    drive_edge();
    out_ready = 1'b1;
    for (int i = 0; i < 16; i++) mem[2 + i] = 8'(i);
    wr_limit = 18;
    for (int i = 0; i < 10 && !out_valid; i++) smp();
    check("stream_start", {31'b0, out_valid}, 32'd1);
    for (int i = 0; i < 16; i++) begin
      check("stream_valid", {31'b0, out_valid}, 32'd1);
      check("stream_data", {24'b0, out_data}, i);
      smp();
    end
    check("stream_end", {31'b0, out_valid}, 32'd0);

    // Backpressure: exactly two reads, then hold.
    drive_edge();
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) mem[18 + i] = 8'h40 + 8'(i);
    wr_limit = 26;
    n_rinc   = 0;
    for (int i = 0; i < 10; i++) begin
      smp();
      if (rinc) n_rinc++;
      if (out_valid) check("bp_stable", {24'b0, out_data}, 32'h40);
    end
    check("bp_rinc_pulses", n_rinc, 32'd2);
    check("bp_count", {30'b0, out_count}, 32'd2);
    check("bp_data", {24'b0, out_data}, 32'h40);
    drive_edge();
    out_ready = 1'b1;
    smp();
    check("bp_rinc_resume", {31'b0, rinc}, 32'd1);
    for (int i = 0; i < 40 && sb_idx != 26; i++) smp();
    check("bp_drained_words", sb_idx, 32'd26);
    smp();
    check("bp_empty", {31'b0, out_valid}, 32'd0);

    // Random ready and empty gaps over 1000 words.
    for (int i = 0; i < 1000; i++) mem[26 + i] = 8'($urandom);
    wr_limit = 1026;
    for (int i = 0; i < 20000 && sb_idx != 1026; i++) begin
      drive_edge();
      out_ready  = 1'($urandom_range(0, 1));
      gate_empty = ($urandom_range(0, 3) == 0);
    end
    check("rand_words", sb_idx, 32'd1026);

    // Reset while holding a word with another in flight.
    drive_edge();
    out_ready  = 1'b0;
    gate_empty = 1'b0;
    for (int i = 0; i < 4; i++) mem[1026 + i] = 8'hC0 + 8'(i);
    wr_limit = 1030;
    repeat (6) smp();
    check("mid_count_full", {30'b0, out_count}, 32'd2);
    drive_edge();
    out_ready = 1'b1;
    smp();
    check("mid_rinc", {31'b0, rinc}, 32'd1);
    drive_edge();
    out_ready = 1'b0;
    smp();
    check("mid_count_one", {30'b0, out_count}, 32'd1);
    rrst_n     = 1'b0;
    gate_empty = 1'b1;
    #1;
    check("mid_rst_rinc", {31'b0, rinc}, 32'd0);
    check("mid_rst_valid", {31'b0, out_valid}, 32'd0);
    check("mid_rst_count", {30'b0, out_count}, 32'd0);
    check("mid_rst_data", {24'b0, out_data}, 32'd0);
    repeat (2) @(posedge rclk);
    #1;
    rrst_n    = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      smp();
      check("post_rst_valid", {31'b0, out_valid}, 32'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
